// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Digit-serial two's-complement subtractor: D = A - B - Bin (mod 2^WIDTH).
//   Processes DIGIT bits per clock, LSB digit first, so a result takes
//   N = WIDTH/DIGIT compute cycles. Borrow-out and signed overflow use the
//   same semantics as the companion adder's carry-out and overflow flags.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   A/B/Bin valid              in_ready   operands accepted (IDLE)
//   A, B, Bin  minuend, subtrahend, borrow-in
//   out_valid  D/Bout/overFlow hold a completed result (DONE)
//   out_ready  consumer takes the result
//   D          difference
//   Bout       unsigned borrow-out (A < B + Bin)
//   overFlow   signed overflow
//   busy       high while digits are being computed (CALC)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             overFlow,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched operands and working state
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    // Presented result registers
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    // Digit datapath
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT:0]   w_sum;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf_nxt;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(N - 1));

    // Select digit k of the latched operands. Constant-index slices keep the
    // mux shape obvious and avoid variable part-selects.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_dig = r_a[k*DIGIT +: DIGIT];
                w_b_dig = r_b[k*DIGIT +: DIGIT];
            end
        end
    end

    // Subtraction as A + ~B + ~borrow; the carry out of the digit is the
    // inverse of the borrow passed to the next digit.
    assign w_sum        = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + {{DIGIT{1'b0}}, ~r_borrow};
    assign w_borrow_nxt = ~w_sum[DIGIT];

    // Working result with the current digit merged in; on the last digit this
    // is the complete difference that gets presented.
    always_comb begin
        w_res_nxt = r_res;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_res_nxt[k*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
            end
        end
    end

    // Signed overflow only possible when operand signs differ; then it is
    // flagged when the result sign disagrees with the minuend.
    assign w_ovf_nxt = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_res_nxt[WIDTH-1] != r_a[WIDTH-1]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_res    <= '0;
            r_borrow <= Bin;
            r_cnt    <= '0;
        end else if (r_state == CALC) begin
            r_res    <= w_res_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Presented result: only updated on the edge that enters DONE, so it is
    // held through backpressure and through the next operation's CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == CALC) && w_last) begin
            r_d    <= w_res_nxt;
            r_bout <= w_borrow_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign D        = r_d;
    assign Bout     = r_bout;
    assign overFlow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;
    localparam int TMO   = 50;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             overFlow;
    logic             busy;

    serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .Bout     (Bout),
        .overFlow (overFlow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width unsigned subtract, borrow is the bit above WIDTH.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t        e;
        logic [WIDTH:0] full;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.d    = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Issue one op, check latency, optionally hold out_ready low for `hold`
    // cycles while offering a competing request, then pop and compare.
    task automatic run(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input exp_t e, input int hold);
        int   n;
        exp_t got;
        @(negedge clk);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        Bin       = bin;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            check({name, " accept timeout"}, 1, 0);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(e);
        @(negedge clk);
        // operands change after the accepting edge and must be ignored
        in_valid = 1'b0;
        A        = ~a;
        B        = ~b;
        Bin      = ~bin;
        check({name, " busy"}, {63'd0, busy}, 64'd1);
        check({name, " in_ready in CALC"}, {63'd0, in_ready}, 64'd0);
        n = 0;
        while (!out_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            check({name, " result timeout"}, 1, 0);
            return;
        end
        check({name, " latency"}, 64'(n), 64'(N));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A        = $urandom;
            B        = $urandom;
            check({name, " held D"}, 64'(D), 64'(e.d));
            check({name, " held flags"}, {62'd0, Bout, overFlow}, {62'd0, e.bout, e.ovf});
            check({name, " held in_ready"}, {63'd0, in_ready}, 64'd0);
            check({name, " held out_valid"}, {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (out_valid && out_ready && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({name, " D"}, 64'(D), 64'(got.d));
            check({name, " Bout"}, {63'd0, Bout}, {63'd0, got.bout});
            check({name, " overFlow"}, {63'd0, overFlow}, {63'd0, got.ovf});
        end else begin
            check({name, " pop"}, 0, 1);
        end
        @(negedge clk);
        check({name, " out_valid drop"}, {63'd0, out_valid}, 64'd0);
        check({name, " back to idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        exp_t e;
        vec_t v;
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;
        int               n;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;

        vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'd10,        32'd5,         1'b0, 32'd5,         1'b0, 1'b0});
        vecs.push_back('{32'd5,         32'd10,        1'b0, 32'hFFFF_FFFB, 1'b1, 1'b0});
        vecs.push_back('{32'd0,         32'd0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{32'd5,         32'd5,         1'b0, 32'd0,         1'b0, 1'b0});
        vecs.push_back('{32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset D", 64'(D), 64'd0);
        check("reset flags", {62'd0, Bout, overFlow}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            e.d = v.d; e.bout = v.bout; e.ovf = v.ovf;
            run($sformatf("vec%0d", i), v.a, v.b, v.bin, e, 0);
        end

        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", i), ra, rb, rbin, model(ra, rb, rbin), 0);
        end

        // Backpressure: result held 10 cycles, competing requests ignored
        run("bp", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0), 10);
        run("after bp", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, model(32'h8000_0000, 32'h7FFF_FFFF, 1'b1), 0);

        // Reset on the 2nd CALC cycle aborts the op
        @(negedge clk);
        in_valid = 1'b1;
        A        = 32'hFFFF_0000;
        B        = 32'h0000_FFFF;
        Bin      = 1'b1;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort pre busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", {63'd0, out_valid}, 64'd0);
        check("abort D", 64'(D), 64'd0);
        check("abort flags", {62'd0, Bout, overFlow}, 64'd0);
        check("abort in_ready", {63'd0, in_ready}, 64'd1);
        check("abort busy", {63'd0, busy}, 64'd0);
        run("post abort", 32'd10, 32'd5, 1'b0, model(32'd10, 32'd5, 1'b0), 0);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
